// File: rtl/nn_pkg.sv
// Types and constants shared by the neuron-layer datapath blocks.
package nn_pkg;

  localparam int NN_WEIGHT_WIDTH = 16;
  localparam int NN_DATA_WIDTH   = 128;
  localparam int LANES_PER_WORD  = NN_DATA_WIDTH / NN_WEIGHT_WIDTH;

  typedef logic signed [NN_WEIGHT_WIDTH-1:0] weight_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    STREAM,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/lane_unpack.sv
// Two-word weight buffer: loads {word_a, word_b} and shifts one lane out per advance,
// so the presented lane is always the buffer's top slice.
module lane_unpack #(
  parameter int DATA_WIDTH   = 128,
  parameter int WEIGHT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    advance,
  input  logic [DATA_WIDTH-1:0]   q_a,
  input  logic [DATA_WIDTH-1:0]   q_b,
  output logic [WEIGHT_WIDTH-1:0] lane_data
);

  logic [2*DATA_WIDTH-1:0] buffer;

  // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is cleared on reset because the weight output is taken directly from it.
    if (!rst_n) begin
      buffer <= '0;
    end else if (load) begin
      buffer <= {q_a, q_b};
    end else if (advance) begin
      buffer <= buffer << WEIGHT_WIDTH;
    end
  end

  assign lane_data = buffer[2*DATA_WIDTH-1 -: WEIGHT_WIDTH];

endmodule

// File: rtl/weight_fetch.sv
// Streams a packed weight ROM, read two words at a time through both ports, as
// signed weights under valid/ready, flagging the final weight of the layer.
module weight_fetch #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int DEPTH        = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int NUM_WEIGHTS  = 122
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          addr_a,
  output logic [ADDR_WIDTH-1:0]          addr_b,
  input  logic [DATA_WIDTH-1:0]          q_a,
  input  logic [DATA_WIDTH-1:0]          q_b,
  output logic                           w_valid,
  input  logic                           w_ready,
  output logic [WEIGHT_WIDTH-1:0]        w_data,
  output logic                           w_last,
  output logic [$clog2(NUM_WEIGHTS)-1:0] w_index
);
  import nn_pkg::*;

  localparam int LANES_PER_PAIR = 2 * (DATA_WIDTH / WEIGHT_WIDTH);
  localparam int LANE_WIDTH     = $clog2(LANES_PER_PAIR);
  localparam int INDEX_WIDTH    = $clog2(NUM_WEIGHTS);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [LANE_WIDTH-1:0]  LAST_LANE  = LANE_WIDTH'(LANES_PER_PAIR - 1);

  fetch_state_e           state;
  logic [ADDR_WIDTH-1:0]  pair;
  logic [ADDR_WIDTH-1:0]  next_pair;
  logic [LANE_WIDTH-1:0]  lane;
  logic [INDEX_WIDTH-1:0] next_index;
  logic                   xfer;
  logic                   load;

  assign xfer       = w_valid && w_ready;
  assign load       = (state == WAIT);
  assign next_pair  = pair + ADDR_WIDTH'(1);
  assign next_index = w_index + INDEX_WIDTH'(1);

  function automatic logic [ADDR_WIDTH-1:0] even_addr(input logic [ADDR_WIDTH-1:0] k);
    return ADDR_WIDTH'(2 * int'(k));
  endfunction

  // Port B past the end of the ROM is parked on the last word; its lanes are never reached.
  function automatic logic [ADDR_WIDTH-1:0] odd_addr(input logic [ADDR_WIDTH-1:0] k);
    int a;
    a = 2 * int'(k) + 1;
    return (a >= DEPTH) ? ADDR_WIDTH'(DEPTH - 1) : ADDR_WIDTH'(a);
  endfunction

  lane_unpack #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_lane_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (xfer),
    .q_a      (q_a),
    .q_b      (q_b),
    .lane_data(w_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_valid <= 1'b0;
      w_last  <= 1'b0;
      w_index <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      pair    <= '0;
      lane    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            pair    <= '0;
            w_index <= '0;
            addr_a  <= even_addr('0);
            addr_b  <= odd_addr('0);
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          state   <= STREAM;
          w_valid <= 1'b1;
          lane    <= '0;
          w_last  <= (w_index == LAST_INDEX);
        end
        STREAM: begin
          if (xfer) begin
            w_index <= next_index;
            lane    <= lane + LANE_WIDTH'(1);
            if (w_last) begin
              state   <= DONE;
              w_valid <= 1'b0;
              w_last  <= 1'b0;
              done    <= 1'b1;
            end else if (lane == LAST_LANE) begin
              // Pair exhausted: two bubble cycles while the next pair is read.
              state   <= FETCH;
              w_valid <= 1'b0;
              w_last  <= 1'b0;
              pair    <= next_pair;
              addr_a  <= even_addr(next_pair);
              addr_b  <= odd_addr(next_pair);
            end else begin
              w_last <= (next_index == LAST_INDEX);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch.sv
// Self-checking bench for weight_fetch: a registered dual-port ROM model feeds the DUT,
// and the weight stream is checked against the ROM contents unpacked in index order.
module tb_weight_fetch;
  import nn_pkg::*;

  localparam int ADDR_WIDTH   = 4;
  localparam int DATA_WIDTH   = 128;
  localparam int DEPTH        = 16;
  localparam int WEIGHT_WIDTH = 16;
  localparam int NUM_WEIGHTS  = 122;
  localparam int IW           = $clog2(NUM_WEIGHTS);
  localparam int LPP          = 2 * LANES_PER_WORD;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    w_ready = 1'b0;
  logic                    busy, done, w_valid, w_last;
  logic [ADDR_WIDTH-1:0]   addr_a, addr_b;
  logic [DATA_WIDTH-1:0]   q_a = '0, q_b = '0;
  logic [WEIGHT_WIDTH-1:0] w_data;
  logic [IW-1:0]           w_index;

  logic [DATA_WIDTH-1:0]   rom [DEPTH];
  logic [WEIGHT_WIDTH-1:0] expected [NUM_WEIGHTS];
  logic [WEIGHT_WIDTH-1:0] key_w [int];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  weight_fetch #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH), .NUM_WEIGHTS(NUM_WEIGHTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_last(w_last), .w_index(w_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model with a one-cycle registered read on both ports.
  always @(posedge clk) begin
    q_a <= rom[addr_a];
    q_b <= rom[addr_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_weight(input int i, input weight_t v);
    rom[i / LANES_PER_WORD][DATA_WIDTH-1-(i % LANES_PER_WORD)*WEIGHT_WIDTH -: WEIGHT_WIDTH] = v;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_busy"},    busy,    0);
    check({pfx, "_done"},    done,    0);
    check({pfx, "_w_valid"}, w_valid, 0);
    check({pfx, "_w_last"},  w_last,  0);
    check({pfx, "_w_data"},  w_data,  0);
    check({pfx, "_w_index"}, w_index, 0);
    check({pfx, "_addr_a"},  addr_a,  0);
    check({pfx, "_addr_b"},  addr_b,  0);
    check({pfx, "_state"},   dut.state, IDLE);
  endtask

  // mode 0: ready always high; 1: random ready; 2: first five valid cycles stalled.
  task automatic run_stream(input int mode, input int poke_idx, input bit timing);
    int n0, idx, dones, lasts, stall, first_valid, last_xfer, done_cyc, end_cyc, bnd_cyc, bnd_k;
    bit fin, poked;
    idx = 0; dones = 0; lasts = 0; stall = 0; fin = 0; poked = 0;
    first_valid = -1; last_xfer = -1; done_cyc = -1; end_cyc = -1; bnd_cyc = -1; bnd_k = 0;
    start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start_addr_a", addr_a, 0);
    check("start_addr_b", addr_b, 1);
    check("start_busy", busy, 1);
    check("start_no_valid", w_valid, 0);
    for (int c = 0; c < 1000 && !fin; c++) begin
      start = 1'b0;
      case (mode)
        1:       w_ready = ($urandom_range(0, 1) == 1);
        2:       w_ready = !(w_valid && stall < 5);
        default: w_ready = 1'b1;
      endcase
      if (mode == 2 && w_valid && !w_ready) begin
        check("bp_data", w_data, 16'hfd45);
        check("bp_index", w_index, 0);
        stall++;
      end
      if (w_valid) begin
        check("valid_implies_busy", busy, 1);
        if (first_valid < 0) first_valid = cyc;
      end
      if (bnd_cyc >= 0) begin
        if (cyc == bnd_cyc + 1) begin
          check("gap1_valid", w_valid, 0);
          check("gap_addr_a", addr_a, 2 * bnd_k);
          check("gap_addr_b", addr_b, (2 * bnd_k + 1 >= DEPTH) ? DEPTH - 1 : 2 * bnd_k + 1);
        end
        if (cyc == bnd_cyc + 2) check("gap2_valid", w_valid, 0);
        if (cyc == bnd_cyc + 3) check("gap_resume_valid", w_valid, 1);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (poke_idx >= 0 && !poked && w_valid && int'(w_index) == poke_idx) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (w_valid && w_ready) begin
        if (idx < NUM_WEIGHTS) check($sformatf("w_data[%0d]", idx), w_data, expected[idx]);
        check($sformatf("w_index[%0d]", idx), w_index, idx);
        check($sformatf("w_last[%0d]", idx), w_last, (idx == NUM_WEIGHTS - 1));
        if (key_w.exists(idx)) check($sformatf("key_weight[%0d]", idx), w_data, key_w[idx]);
        if (w_last) begin
          lasts++;
          last_xfer = cyc;
        end
        if (idx % LPP == LPP - 1 && idx < NUM_WEIGHTS - 1) begin
          bnd_cyc = cyc;
          bnd_k   = idx / LPP + 1;
        end
        idx++;
      end
      if (dones > 0 && !busy) begin
        fin = 1'b1;
        end_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("stream_finished", fin, 1);
    check("xfer_count", idx, NUM_WEIGHTS);
    check("last_count", lasts, 1);
    check("done_count", dones, 1);
    if (timing) begin
      check("first_valid_cycle", first_valid - n0, 3);
      check("last_xfer_cycle", last_xfer - n0, 138);
      check("done_cycle", done_cyc - n0, 139);
      check("busy_low_cycle", end_cyc - n0, 140);
    end
  endtask

  task automatic reset_mid_stream();
    bit hit;
    hit = 1'b0;
    w_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      if (w_valid && w_index == IW'(60)) hit = 1'b1;
      else @(negedge clk);
    end
    check("reach_index_60", hit, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int w = 0; w < DEPTH; w++) rom[w] = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_w[0]   = 16'hfd45;
    key_w[1]   = 16'hf68c;
    key_w[7]   = 16'h05b6;
    key_w[8]   = 16'hfe1d;
    key_w[16]  = 16'hff5b;
    key_w[120] = 16'h07de;
    key_w[121] = 16'heaa1;
    foreach (key_w[i]) set_weight(i, weight_t'(key_w[i]));
    for (int i = 0; i < NUM_WEIGHTS; i++)
      expected[i] = rom[i / LANES_PER_WORD][DATA_WIDTH-1-(i % LANES_PER_WORD)*WEIGHT_WIDTH -: WEIGHT_WIDTH];

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_stream(0, -1, 1'b1);
    run_stream(2, -1, 1'b0);
    run_stream(0, 40, 1'b1);
    reset_mid_stream();
    run_stream(0, -1, 1'b1);
    run_stream(1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
